// File: rtl/debounce_multi.sv
// Multi-channel button/switch debouncer: per-channel synchroniser, symmetric
// press/release debounce FSM and optional auto-repeat tick generator.
module debounce_multi #(
    parameter int unsigned CH          = 4,
    parameter int unsigned N           = 22,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REPEAT_EN   = 0,
    parameter int unsigned R           = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] btn,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] press_tick,
    output logic [CH-1:0] release_tick,
    output logic [CH-1:0] repeat_tick,
    output logic          any_level
);

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    localparam logic [N-1:0] CNT_ONE    = 1;
    localparam logic [R:0]   REP_ONE    = 1;
    localparam logic [R:0]   REP_TOP    = '1;
    localparam logic [R:0]   REP_RELOAD = {1'b1, {R{1'b0}}};

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_t                 state_q, state_d;
        logic [N-1:0]           cnt_q, cnt_d;
        logic [R:0]             rep_q, rep_d;
        logic                   db_q, press_q, release_q, repeat_q;
        logic                   press_d, release_d, repeat_d;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn[i]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            rep_d     = rep_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            repeat_d  = 1'b0;
            case (state_q)
                ZERO: begin
                    if (s) begin
                        cnt_d   = '1;
                        state_d = WAIT1;
                    end
                end
                WAIT1: begin
                    if (!s) begin
                        state_d = ZERO;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        state_d = ONE;
                        press_d = 1'b1;
                        rep_d   = '0;
                    end
                end
                ONE: begin
                    if (!s) begin
                        cnt_d   = '1;
                        state_d = WAIT0;
                    end else if (REPEAT_EN != 0) begin
                        // Counter holds at the top value for one cycle, then
                        // restarts half-way so later repeats are 2^R apart.
                        if (rep_q == REP_TOP) begin
                            repeat_d = 1'b1;
                            rep_d    = REP_RELOAD;
                        end else begin
                            rep_d = rep_q + REP_ONE;
                        end
                    end
                end
                WAIT0: begin
                    if (s) begin
                        state_d = ONE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        state_d   = ZERO;
                        release_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ZERO;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q   <= ZERO;
                cnt_q     <= '0;
                rep_q     <= '0;
                db_q      <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                rep_q     <= rep_d;
                db_q      <= (state_d == ONE) || (state_d == WAIT0);
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
            end
        end

        assign db_level[i]     = db_q;
        assign press_tick[i]   = press_q;
        assign release_tick[i] = release_q;
        assign repeat_tick[i]  = repeat_q;
    end

    assign any_level = |db_level;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed latencies.
module tb_debounce_multi;

    localparam int CH     = 4;
    localparam int N      = 3;
    localparam int SYNC   = 2;
    localparam int R      = 2;
    localparam int STABLE = (1 << N) + 1;
    localparam int FIRST  = 1 << (R + 1);
    localparam int PERIOD = 1 << R;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] btn = '0;
    logic [CH-1:0] db_level, press_tick, release_tick, repeat_tick;
    logic          any_level;
    logic [CH-1:0] nr_db, nr_press, nr_release, nr_repeat;
    logic          nr_any;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    debounce_multi #(.CH(CH), .N(N), .SYNC_STAGES(SYNC), .REPEAT_EN(1), .R(R)) u_dut (
        .clk(clk), .reset(reset), .btn(btn),
        .db_level(db_level), .press_tick(press_tick), .release_tick(release_tick),
        .repeat_tick(repeat_tick), .any_level(any_level)
    );

    debounce_multi #(.CH(CH), .N(N), .SYNC_STAGES(SYNC), .REPEAT_EN(0), .R(R)) u_norep (
        .clk(clk), .reset(reset), .btn(btn),
        .db_level(nr_db), .press_tick(nr_press), .release_tick(nr_release),
        .repeat_tick(nr_repeat), .any_level(nr_any)
    );

    // Reference: level flips after STABLE consecutive disagreeing samples;
    // repeats counted from edges spent held high with a settled level.
    bit            pipe [CH][SYNC];
    int            run  [CH];
    int            held [CH];
    bit            lvl  [CH];
    logic [CH-1:0] m_db = '0, m_press = '0, m_rel = '0, m_rep = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CH; c++) begin
                for (int j = 0; j < SYNC; j++) pipe[c][j] <= 1'b0;
                run[c]  <= 0;
                held[c] <= 0;
                lvl[c]  <= 1'b0;
            end
            m_db <= '0; m_press <= '0; m_rel <= '0; m_rep <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                automatic bit s    = pipe[c][SYNC-1];
                automatic int r    = (s != lvl[c]) ? run[c] + 1 : 0;
                automatic int h    = held[c];
                automatic bit flip = (r == STABLE);
                automatic bit rp   = 1'b0;
                if (lvl[c] && run[c] == 0 && s) begin
                    h  = h + 1;
                    rp = (h >= FIRST) && (((h - FIRST) % PERIOD) == 0);
                end
                if (flip) begin
                    r = 0;
                    if (!lvl[c]) h = 0;
                end
                run[c]     <= r;
                held[c]    <= h;
                lvl[c]     <= lvl[c] ^ flip;
                m_db[c]    <= lvl[c] ^ flip;
                m_press[c] <= flip & !lvl[c];
                m_rel[c]   <= flip & lvl[c];
                m_rep[c]   <= rp;
                for (int j = SYNC - 1; j > 0; j--) pipe[c][j] <= pipe[c][j-1];
                pipe[c][0] <= btn[c];
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [16:0] act, exp_v;
        exp_v = {m_db, m_press, m_rel, m_rep, |m_db};
        act   = {db_level, press_tick, release_tick, repeat_tick, any_level};
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL model_rep t=%0t: got %h expected %h", $time, act, exp_v);
        exp_v = {m_db, m_press, m_rel, 4'b0000, |m_db};
        act   = {nr_db, nr_press, nr_release, nr_repeat, nr_any};
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL model_norep t=%0t: got %h expected %h", $time, act, exp_v);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        bit quiet;

        repeat (3) step();
        chk("reset_outputs", {db_level, press_tick, release_tick, repeat_tick, any_level}, 0);
        reset = 1'b1;
        repeat (3) step();

        // 1: clean press on channel 0
        btn[0] = 1'b1;
        repeat (10) step();
        chk("s1_press_early", {press_tick[0], db_level[0]}, 2'b00);
        step();
        chk("s1_press", {press_tick[0], db_level[0], any_level}, 3'b111);
        step();
        chk("s1_press_one_cycle", {press_tick[0], db_level[0]}, 2'b01);

        // 2: bouncing channel 1, then hold high
        quiet = 1'b0;
        for (int t = 0; t < 10; t++) begin
            btn[1] = ~btn[1];
            repeat (4) begin
                step();
                quiet |= press_tick[1] | db_level[1] | release_tick[1];
            end
        end
        chk("s2_bounce_quiet", {31'd0, quiet}, 0);
        btn[1] = 1'b1;
        repeat (10) step();
        chk("s2_press_early", {31'd0, press_tick[1]}, 0);
        step();
        chk("s2_press", {press_tick[1], db_level[1]}, 2'b11);

        // 3: release glitch on channel 2
        btn[2] = 1'b1;
        repeat (12) step();
        chk("s3_held", {31'd0, db_level[2]}, 1);
        btn[2] = 1'b0;
        quiet = 1'b0;
        repeat (5) step();
        btn[2] = 1'b1;
        repeat (12) begin
            step();
            quiet |= release_tick[2] | press_tick[2] | !db_level[2];
        end
        chk("s3_glitch_quiet", {31'd0, quiet}, 0);
        btn[2] = 1'b0;
        repeat (10) step();
        chk("s3_release_early", {release_tick[2], db_level[2]}, 2'b01);
        step();
        chk("s3_release", {release_tick[2], db_level[2]}, 2'b10);
        step();
        chk("s3_release_one_cycle", {31'd0, release_tick[2]}, 0);

        // 4: auto-repeat on channel 3
        btn[3] = 1'b1;
        repeat (11) step();
        chk("s4_press", {31'd0, press_tick[3]}, 1);
        repeat (7) step();
        chk("s4_rep_p7", {31'd0, repeat_tick[3]}, 0);
        step();
        chk("s4_rep_p8", {31'd0, repeat_tick[3]}, 1);
        chk("s4_norep_p8", {28'd0, nr_repeat}, 0);
        repeat (3) step();
        chk("s4_rep_p11", {31'd0, repeat_tick[3]}, 0);
        step();
        chk("s4_rep_p12", {31'd0, repeat_tick[3]}, 1);
        repeat (4) step();
        chk("s4_rep_p16", {31'd0, repeat_tick[3]}, 1);

        // 5: simultaneous channels 0 and 3
        btn = '0;
        repeat (15) step();
        chk("s5_all_low", {31'd0, any_level}, 0);
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        repeat (11) step();
        chk("s5_press_both", {28'd0, press_tick}, 32'h9);
        btn[0] = 1'b0;
        btn[3] = 1'b0;
        repeat (11) step();
        chk("s5_release_both", {28'd0, release_tick}, 32'h9);

        // 6: asynchronous reset with ch0 in WAIT1 and ch1 in ONE
        btn[1] = 1'b1;
        repeat (11) step();
        chk("s6_ch1_one", {28'd0, db_level}, 32'h2);
        btn[0] = 1'b1;
        repeat (5) step();
        chk("s6_ch0_pending", {28'd0, db_level}, 32'h2);
        #2 reset = 1'b0;
        #1;
        chk("s6_async_clear", {db_level, press_tick, release_tick, repeat_tick, any_level}, 0);
        repeat (3) step();
        reset = 1'b1;
        repeat (10) step();
        chk("s6_repress_early", {28'd0, press_tick}, 0);
        step();
        chk("s6_repress", {press_tick, db_level}, 32'h33);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
